// File: rtl/checker_line_arbiter_if.sv
// checker_line_arbiter_if: trace-source, checker and result signals of the line arbiter
interface checker_line_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [8*N_REQ-1:0] req_char;
  logic [16*N_REQ-1:0] req_freq;
  logic [N_REQ-1:0] req_ready;
  logic [7:0] chk_char;
  logic [15:0] chk_freq;
  logic [1:0] chk_format_type;
  logic [3:0] chk_error_code;
  logic res_valid;
  logic [ID_W-1:0] res_id;
  logic [1:0] res_format;
  logic [3:0] res_error;
  logic res_abort;
  logic busy;
  modport master (
    output req_valid, req_char, req_freq, chk_format_type, chk_error_code,
    input req_ready, chk_char, chk_freq, res_valid, res_id, res_format, res_error, res_abort, busy
  );
  modport slave (
    input req_valid, req_char, req_freq, chk_format_type, chk_error_code,
    output req_ready, chk_char, chk_freq, res_valid, res_id, res_format, res_error, res_abort, busy
  );
endinterface

// File: rtl/checker_line_arbiter.sv
// checker_line_arbiter: round-robin, whole-line sharing of one cpu_checker among trace sources
module checker_line_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int MAX_LEN = 64,
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input logic clk,
  input logic reset,
  checker_line_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_REPORT} state_t;
  localparam logic [6:0] L_MAX = 7'(MAX_LEN);
  state_t r_state, w_next;
  logic [ID_W-1:0] r_rr, r_id, r_res_id, w_win;
  logic [6:0] r_len, w_len_inc;
  logic [15:0] r_freq;
  logic [1:0] r_res_format;
  logic [3:0] r_res_error;
  logic r_res_valid, r_res_abort;
  logic [N_REQ-1:0] w_caret, w_ready;
  logic w_hit, w_arb, w_vid, w_grant;
  logic [7:0] w_cid, w_char;
  assign w_arb = r_state == S_IDLE || r_state == S_REPORT;
  assign w_vid = bus.req_valid[r_id];
  assign w_cid = bus.req_char[8*r_id +: 8];
  assign w_len_inc = &r_len ? r_len : r_len + 7'd1;
  assign w_grant = w_arb && w_hit;
  // requesters currently offering a line start '^'
  always_comb begin
    for (int i = 0; i < N_REQ; i++) w_caret[i] = bus.req_valid[i] && bus.req_char[8*i +: 8] == 8'h5e;
  end
  // first '^' holder at or after r_rr wins; scanning downward lets the nearest one overwrite
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_caret[(int'(r_rr) + k) % N_REQ]) begin
        w_hit = 1'b1;
        w_win = ID_W'((int'(r_rr) + k) % N_REQ);
      end
    end
  end
  // state register
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
  // next state; REPORT re-arbitrates so a new line can start alongside the result strobe
  always_comb begin
    w_next = w_arb ? (w_hit ? S_STREAM : S_IDLE)
           : r_state == S_WAIT ? S_REPORT
           : !w_vid ? S_REPORT
           : w_cid == 8'h23 ? S_WAIT
           : w_len_inc == L_MAX ? S_REPORT : S_STREAM;
  end
  // ready and forwarded char; non-'^' chars are drained while no line is owned
  always_comb begin
    w_ready = '0;
    w_char = IDLE_CHAR;
    if (!reset && r_state == S_STREAM) begin
      w_ready[r_id] = w_vid;
      w_char = w_vid ? w_cid : IDLE_CHAR;
    end else if (!reset && w_arb) begin
      for (int i = 0; i < N_REQ; i++)
        w_ready[i] = bus.req_valid[i] && (!w_caret[i] || (w_hit && w_win == ID_W'(i)));
      w_char = w_hit ? 8'h5e : IDLE_CHAR;
    end
  end
  // grant bookkeeping, line length and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
      r_id <= '0;
      r_len <= '0;
      r_freq <= '0;
      r_res_valid <= 1'b0;
      r_res_id <= '0;
      r_res_format <= '0;
      r_res_error <= '0;
      r_res_abort <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_grant) begin
        r_rr <= w_win == ID_W'(N_REQ - 1) ? '0 : w_win + 1'b1;
        r_id <= w_win;
        r_len <= 7'd1;
        r_freq <= bus.req_freq[16*w_win +: 16];
      end
      if (r_state == S_STREAM && w_vid) r_len <= w_len_inc;
      if (r_state == S_WAIT || (r_state == S_STREAM && w_next == S_REPORT)) begin
        r_res_valid <= 1'b1;
        r_res_id <= r_id;
        r_res_abort <= r_state == S_STREAM;
        r_res_format <= r_state == S_WAIT ? bus.chk_format_type : 2'd0;
        r_res_error <= r_state == S_WAIT ? bus.chk_error_code : 4'd0;
      end
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.chk_char = w_char;
  assign bus.chk_freq = r_freq;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id = r_res_id;
  assign bus.res_format = r_res_format;
  assign bus.res_error = r_res_error;
  assign bus.res_abort = r_res_abort;
  assign bus.busy = r_state != S_IDLE;
endmodule

// File: tb/tb_checker_line_arbiter.sv
// tb_checker_line_arbiter: directed scoreboard bench for the checker line arbiter
module tb_checker_line_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0] fmt;
    logic [3:0] err;
    logic abort;
  } res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  res_t q[$];
  res_t m_e;
  string s1 = "^10@00003000: $3 <= 0000000f#";
  string s2 = "^3@00003004: *00000010 <= 12345678#";
  string s3 = "^7@00000001: *00003001 <= 00000000#";
  string s4 = "^12@";
  string s6 = "^5@0";
  string s7 = "^1@00003000: $1 <= 00000001#";
  always #5 clk = ~clk;
  checker_line_arbiter_if #(.N_REQ(N), .ID_W(IW)) tb_if ();
  checker_line_arbiter #(.N_REQ(N), .ID_W(IW), .MAX_LEN(64), .IDLE_CHAR(8'h00)) dut (
    .clk(clk),
    .reset(reset),
    .bus(tb_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int r, input logic [7:0] c, input logic v);
    tb_if.req_valid[r] = v;
    tb_if.req_char[8*r +: 8] = c;
  endtask

  task automatic send_char(input int r, input logic [7:0] c, input string tag);
    int n = 0;
    put(r, c, 1'b1);
    @(negedge clk);
    while (!tb_if.req_ready[r] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(tb_if.req_ready[r]), 32'd1);
    chk({tag, "_chr"}, 32'(tb_if.chk_char), 32'(c));
    tick();
  endtask

  task automatic finish_line(input int r, input logic [1:0] fm, input logic [3:0] er, input string tag);
    put(r, 8'h00, 1'b0);
    tb_if.chk_format_type = fm;
    tb_if.chk_error_code = er;
    @(negedge clk);
    chk({tag, "_wait_rv"}, 32'(tb_if.res_valid), 32'd0);
    chk({tag, "_wait_chr"}, 32'(tb_if.chk_char), 32'd0);
    tick();
    tb_if.chk_format_type = 2'd3;
    tb_if.chk_error_code = 4'hf;
    @(negedge clk);
    chk({tag, "_rep_rv"}, 32'(tb_if.res_valid), 32'd1);
    tick();
  endtask

  task automatic send_line(input int r, input string s, input int from, input logic [15:0] f,
                           input logic [1:0] fm, input logic [3:0] er, input string tag);
    tb_if.req_freq[16*r +: 16] = f;
    q.push_back({IW'(r), fm, er, 1'b0});
    for (int k = from; k < s.len(); k++) send_char(r, s[k], tag);
    finish_line(r, fm, er, tag);
  endtask

  always @(negedge clk) begin
    if (tb_if.res_valid) begin
      if (q.size() == 0) chk("res_unexpected", 32'(tb_if.res_valid), 32'd0);
      else begin
        m_e = q.pop_front();
        chk("res_id", 32'(tb_if.res_id), 32'(m_e.id));
        chk("res_format", 32'(tb_if.res_format), 32'(m_e.fmt));
        chk("res_error", 32'(tb_if.res_error), 32'(m_e.err));
        chk("res_abort", 32'(tb_if.res_abort), 32'(m_e.abort));
      end
    end
  end

  initial begin
    tb_if.req_valid = '0;
    tb_if.req_char = '0;
    tb_if.req_freq = '0;
    tb_if.chk_format_type = 2'd3;
    tb_if.chk_error_code = 4'hf;
    put(0, "x", 1'b1);
    @(negedge clk);
    chk("rst_ready", 32'(tb_if.req_ready), 32'd0);
    chk("rst_busy", 32'(tb_if.busy), 32'd0);
    chk("rst_rv", 32'(tb_if.res_valid), 32'd0);
    chk("rst_chr", 32'(tb_if.chk_char), 32'd0);
    chk("rst_freq", 32'(tb_if.chk_freq), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_drop_rdy", 32'(tb_if.req_ready[0]), 32'd1);
    chk("idle_drop_chr", 32'(tb_if.chk_char), 32'd0);
    tick();
    put(0, 8'h00, 1'b0);
    // two '^' in one cycle with rr_ptr=0: requester 1 wins, 2 waits
    tb_if.req_freq[16 +: 16] = 16'h0011;
    tb_if.req_freq[32 +: 16] = 16'h0022;
    put(1, "^", 1'b1);
    put(2, "^", 1'b1);
    @(negedge clk);
    chk("t2_rdy1", 32'(tb_if.req_ready[1]), 32'd1);
    chk("t2_rdy2", 32'(tb_if.req_ready[2]), 32'd0);
    chk("t2_chr", 32'(tb_if.chk_char), 32'h5e);
    tick();
    put(1, s1[1], 1'b1);
    @(negedge clk);
    chk("t2_busy", 32'(tb_if.busy), 32'd1);
    chk("t2_freq", 32'(tb_if.chk_freq), 32'h11);
    chk("t2_hold2", 32'(tb_if.req_ready[2]), 32'd0);
    chk("t2_rdy1b", 32'(tb_if.req_ready[1]), 32'd1);
    tick();
    send_line(1, s1, 2, 16'h0011, 2'd1, 4'h0, "t2a");
    send_line(2, s2, 1, 16'h0022, 2'd2, 4'h0, "t2b");
    chk("t2b_freq", 32'(tb_if.chk_freq), 32'h22);
    // rr_ptr now 3: requester 3 beats requester 0
    tb_if.req_freq[0 +: 16] = 16'h0004;
    tb_if.req_freq[48 +: 16] = 16'h0004;
    put(0, "^", 1'b1);
    put(3, "^", 1'b1);
    @(negedge clk);
    chk("t3_rdy3", 32'(tb_if.req_ready[3]), 32'd1);
    chk("t3_rdy0", 32'(tb_if.req_ready[0]), 32'd0);
    tick();
    send_line(3, s3, 1, 16'h0004, 2'd2, 4'b0111, "t3");
    // requester 0 was granted during requester 3's REPORT
    send_line(0, s1, 1, 16'h0004, 2'd1, 4'h0, "t1");
    chk("t1_freq", 32'(tb_if.chk_freq), 32'h4);
    // stall after "^12@"
    q.push_back({IW'(0), 2'd0, 4'h0, 1'b1});
    for (int k = 0; k < s4.len(); k++) send_char(0, s4[k], "t4");
    put(0, "5", 1'b0);
    @(negedge clk);
    chk("t4_stall_chr", 32'(tb_if.chk_char), 32'd0);
    chk("t4_stall_rdy", 32'(tb_if.req_ready[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_rep_rv", 32'(tb_if.res_valid), 32'd1);
    tick();
    // overlength: 64th char consumed, then abort; later chars drained
    q.push_back({IW'(1), 2'd0, 4'h0, 1'b1});
    for (int k = 0; k < 64; k++) send_char(1, k == 0 ? 8'h5e : 8'h61, "t5");
    for (int k = 64; k < 70; k++) begin
      put(1, 8'h61, 1'b1);
      @(negedge clk);
      chk("t5_drop_rdy", 32'(tb_if.req_ready[1]), 32'd1);
      chk("t5_drop_chr", 32'(tb_if.chk_char), 32'd0);
      if (k == 64) chk("t5_rep_rv", 32'(tb_if.res_valid), 32'd1);
      else chk("t5_released", 32'(tb_if.busy), 32'd0);
      tick();
    end
    put(1, 8'h00, 1'b0);
    // reset mid-line drops the line silently
    tb_if.req_freq[32 +: 16] = 16'h0077;
    for (int k = 0; k < s6.len(); k++) send_char(2, s6[k], "t6");
    chk("t6_freq", 32'(tb_if.chk_freq), 32'h77);
    put(2, "1", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_rdy", 32'(tb_if.req_ready), 32'd0);
    tick();
    reset = 1'b0;
    put(2, 8'h00, 1'b0);
    @(negedge clk);
    chk("t6_busy", 32'(tb_if.busy), 32'd0);
    chk("t6_rv", 32'(tb_if.res_valid), 32'd0);
    chk("t6_id", 32'(tb_if.res_id), 32'd0);
    chk("t6_fmt", 32'(tb_if.res_format), 32'd0);
    chk("t6_err", 32'(tb_if.res_error), 32'd0);
    chk("t6_abort", 32'(tb_if.res_abort), 32'd0);
    chk("t6_freq0", 32'(tb_if.chk_freq), 32'd0);
    chk("t6_chr", 32'(tb_if.chk_char), 32'd0);
    repeat (6) tick();
    // after reset rr_ptr=0 and normal operation resumes
    send_line(0, s7, 0, 16'h0009, 2'd1, 4'h0, "t7");
    repeat (3) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
